// File: rtl/approx_mul_accumulator.sv
// Frame accumulator for approximate-multiplier products with a valid/ready result port.
// Optional ACC_SAT_EN: saturate the sum at all-ones on overflow instead of wrapping.
module approx_mul_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LEN_C = 8'(LEN);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               accept_s;
  logic [ACC_W-1:0]   base_s;
  logic [ACC_W:0]     sum_s;
  logic [7:0]         cnt_inc_s;
  logic               last_s;
  logic [ACC_W-1:0]   acc_next_s;
  logic               ovf_next_s;

  // Beat acceptance and the adder datapath; IDLE starts from zero so a load is an add
  always_comb begin
    in_ready  = (state_q != ST_DONE) && !clr;
    accept_s  = in_valid && in_ready;
    base_s    = (state_q == ST_IDLE) ? {ACC_W{1'b0}} : acc_q;
    sum_s     = {1'b0, base_s} + {1'b0, ACC_W'(in_prod)};
    cnt_inc_s = ((state_q == ST_IDLE) ? 8'd0 : cnt_q) + 8'd1;
    last_s    = in_last || (cnt_inc_s == LEN_C);
    ovf_next_s = ovf_q || sum_s[ACC_W];
`ifdef ACC_SAT_EN
    if (ovf_next_s) begin
      acc_next_s = {ACC_W{1'b1}};
    end else begin
      acc_next_s = sum_s[ACC_W-1:0];
    end
`else
    acc_next_s = sum_s[ACC_W-1:0];
`endif
  end

  // Next-state and frame register updates; clr overrides every other event
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept_s) begin
          acc_d   = acc_next_s;
          cnt_d   = cnt_inc_s;
          ovf_d   = ovf_next_s;
          state_d = last_s ? ST_DONE : ST_ACCUM;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = {ACC_W{1'b0}};
        cnt_d   = 8'd0;
        ovf_d   = 1'b0;
      end
    endcase
    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = {ACC_W{1'b0}};
      cnt_d   = 8'd0;
      ovf_d   = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State and frame registers with asynchronous reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_approx_mul_accumulator.sv
// Scoreboard bench: instance a (ACC_W=24, LEN=4) for framing, instance b (ACC_W=16, LEN=2) for overflow.
module tb_approx_mul_accumulator;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;

  logic        a_clr = 1'b0, a_valid = 1'b0, a_last = 1'b0, a_oready = 1'b0;
  logic [15:0] a_prod = 16'd0;
  logic        a_iready, a_ovalid, a_ovf;
  logic [23:0] a_acc;
  logic [7:0]  a_cnt;

  logic        b_clr = 1'b0, b_valid = 1'b0, b_last = 1'b0, b_oready = 1'b0;
  logic [15:0] b_prod = 16'd0;
  logic        b_iready, b_ovalid, b_ovf;
  logic [15:0] b_acc;
  logic [7:0]  b_cnt;

  typedef struct {
    logic [31:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  approx_mul_accumulator #(.ACC_W(24), .LEN(4)) u_a (
    .CLK(CLK), .RST_N(RST_N), .clr(a_clr), .in_valid(a_valid), .in_ready(a_iready),
    .in_prod(a_prod), .in_last(a_last), .out_valid(a_ovalid), .out_ready(a_oready),
    .out_acc(a_acc), .out_count(a_cnt), .out_ovf(a_ovf)
  );

  approx_mul_accumulator #(.ACC_W(16), .LEN(2)) u_b (
    .CLK(CLK), .RST_N(RST_N), .clr(b_clr), .in_valid(b_valid), .in_ready(b_iready),
    .in_prod(b_prod), .in_last(b_last), .out_valid(b_ovalid), .out_ready(b_oready),
    .out_acc(b_acc), .out_count(b_cnt), .out_ovf(b_ovf)
  );

  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic send_a(input logic [15:0] prod, input logic last);
    @(negedge CLK);
    a_valid = 1'b1;
    a_prod  = prod;
    a_last  = last;
  endtask

  task automatic send_b(input logic [15:0] prod, input logic last);
    @(negedge CLK);
    b_valid = 1'b1;
    b_prod  = prod;
    b_last  = last;
  endtask

  task automatic stop_inputs();
    @(negedge CLK);
    a_valid = 1'b0; a_last = 1'b0; a_prod = 16'd0;
    b_valid = 1'b0; b_last = 1'b0; b_prod = 16'd0;
  endtask

  // Wait (bounded) for a result on the selected instance, compare to the scoreboard, then consume it.
  task automatic collect(input logic sel_b, input string name);
    int   waited;
    exp_t e;
    logic        ov, ovf, ir;
    logic [31:0] acc;
    logic [7:0]  cnt;
    waited = 0;
    ov = sel_b ? b_ovalid : a_ovalid;
    while (!ov && waited < 20) begin
      @(negedge CLK);
      waited++;
      ov = sel_b ? b_ovalid : a_ovalid;
    end
    total++;
    if (!ov) begin
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", name, waited);
      return;
    end
    passed++;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s_unexpected: result seen with empty scoreboard", name);
      return;
    end
    passed++;
    e   = sb.pop_front();
    acc = sel_b ? {16'd0, b_acc} : {8'd0, a_acc};
    cnt = sel_b ? b_cnt : a_cnt;
    ovf = sel_b ? b_ovf : a_ovf;
    total++;
    if (acc !== e.acc) $display("FAIL %s_acc: got 0x%0h required 0x%0h", name, acc, e.acc);
    else passed++;
    total++;
    if (cnt !== e.cnt) $display("FAIL %s_count: got %0d required %0d", name, cnt, e.cnt);
    else passed++;
    total++;
    if (ovf !== e.ovf) $display("FAIL %s_ovf: got %0b required %0b", name, ovf, e.ovf);
    else passed++;
    if (sel_b) b_oready = 1'b1; else a_oready = 1'b1;
    @(negedge CLK);
    a_oready = 1'b0;
    b_oready = 1'b0;
    ov = sel_b ? b_ovalid : a_ovalid;
    ir = sel_b ? b_iready : a_iready;
    total++;
    if (ov !== 1'b0) $display("FAIL %s_valid_drop: out_valid=%0b required 0", name, ov);
    else passed++;
    total++;
    if (ir !== 1'b1) $display("FAIL %s_ready_back: in_ready=%0b required 1", name, ir);
    else passed++;
  endtask

  task automatic test_reset();
    #2;
    total++; if (a_ovalid !== 1'b0) $display("FAIL rst_valid: got %0b required 0", a_ovalid); else passed++;
    total++; if (a_acc !== 24'd0) $display("FAIL rst_acc: got %0h required 0", a_acc); else passed++;
    total++; if (a_cnt !== 8'd0) $display("FAIL rst_count: got %0d required 0", a_cnt); else passed++;
    total++; if (a_ovf !== 1'b0) $display("FAIL rst_ovf: got %0b required 0", a_ovf); else passed++;
    total++; if (a_iready !== 1'b1) $display("FAIL rst_in_ready: got %0b required 1", a_iready); else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_full_frame_backpressure();
    logic [23:0] acc0;
    send_a(16'd100, 1'b0);
    send_a(16'd200, 1'b0);
    send_a(16'd300, 1'b0);
    send_a(16'd400, 1'b0);
    sb.push_back('{acc: 32'd1000, cnt: 8'd4, ovf: 1'b0});
    // The frame closed on LEN; keep offering a beat that must be refused while stalled.
    @(negedge CLK);
    a_prod = 16'd7;
    total++; if (a_ovalid !== 1'b1) $display("FAIL latency: out_valid=%0b required 1", a_ovalid); else passed++;
    acc0 = 24'd1000;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (a_ovalid !== 1'b1 || a_acc !== acc0 || a_cnt !== 8'd4 || a_iready !== 1'b0)
        $display("FAIL stall_%0d: valid=%0b acc=%0d cnt=%0d in_ready=%0b required 1/%0d/4/0",
                 i, a_ovalid, a_acc, a_cnt, a_iready, acc0);
      else passed++;
      @(negedge CLK);
    end
    a_valid = 1'b0;
    a_prod  = 16'd0;
    collect(1'b0, "full_frame");
  endtask

  task automatic test_early_last();
    send_a(16'hFFFF, 1'b0);
    send_a(16'h0001, 1'b1);
    sb.push_back('{acc: 32'h0001_0000, cnt: 8'd2, ovf: 1'b0});
    stop_inputs();
    collect(1'b0, "early_last");
  endtask

  task automatic test_overflow();
    send_b(16'hFFFF, 1'b0);
    send_b(16'h0002, 1'b0);
`ifdef ACC_SAT_EN
    sb.push_back('{acc: 32'h0000_FFFF, cnt: 8'd2, ovf: 1'b1});
`else
    sb.push_back('{acc: 32'h0000_0001, cnt: 8'd2, ovf: 1'b1});
`endif
    stop_inputs();
    collect(1'b1, "overflow");
  endtask

  task automatic test_abort();
    send_a(16'd50, 1'b0);
    send_a(16'd50, 1'b0);
    @(negedge CLK);
    a_clr = 1'b1;
    a_prod = 16'd50;
    #1;
    total++; if (a_iready !== 1'b0) $display("FAIL clr_in_ready: got %0b required 0", a_iready); else passed++;
    @(negedge CLK);
    a_clr = 1'b0;
    a_valid = 1'b0;
    total++;
    if (a_cnt !== 8'd0 || a_acc !== 24'd0 || a_ovalid !== 1'b0)
      $display("FAIL clr_state: cnt=%0d acc=%0d valid=%0b required 0/0/0", a_cnt, a_acc, a_ovalid);
    else passed++;
    for (int i = 0; i < 4; i++) send_a(16'd10, 1'b0);
    sb.push_back('{acc: 32'd40, cnt: 8'd4, ovf: 1'b0});
    stop_inputs();
    collect(1'b0, "after_abort");
  endtask

  task automatic test_clr_in_done();
    send_a(16'd5, 1'b0);
    send_a(16'd5, 1'b1);
    stop_inputs();
    total++; if (a_ovalid !== 1'b1) $display("FAIL done_pending: out_valid=%0b required 1", a_ovalid); else passed++;
    a_clr = 1'b1;
    @(negedge CLK);
    a_clr = 1'b0;
    total++;
    if (a_ovalid !== 1'b0 || a_cnt !== 8'd0)
      $display("FAIL clr_done: valid=%0b cnt=%0d required 0/0", a_ovalid, a_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    send_a(16'd1, 1'b0);
    send_a(16'd2, 1'b0);
    send_a(16'd3, 1'b0);
    stop_inputs();
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if (a_ovalid !== 1'b0 || a_acc !== 24'd0 || a_cnt !== 8'd0 || a_ovf !== 1'b0)
      $display("FAIL mid_reset: valid=%0b acc=%0d cnt=%0d ovf=%0b required all 0", a_ovalid, a_acc, a_cnt, a_ovf);
    else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      total++; if (a_ovalid !== 1'b0) $display("FAIL mid_reset_no_valid_%0d: got 1 required 0", i); else passed++;
    end
    send_a(16'd1, 1'b0);
    send_a(16'd2, 1'b0);
    send_a(16'd3, 1'b0);
    send_a(16'd4, 1'b0);
    sb.push_back('{acc: 32'd10, cnt: 8'd4, ovf: 1'b0});
    stop_inputs();
    collect(1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    send_a(16'd7, 1'b0);
    send_a(16'd8, 1'b1);
    sb.push_back('{acc: 32'd15, cnt: 8'd2, ovf: 1'b0});
    stop_inputs();
    collect(1'b0, "b2b_first");
    // in_last on the beat that also reaches LEN must close one frame only.
    send_a(16'd1, 1'b0);
    send_a(16'd1, 1'b0);
    send_a(16'd1, 1'b0);
    send_a(16'd1, 1'b1);
    sb.push_back('{acc: 32'd4, cnt: 8'd4, ovf: 1'b0});
    stop_inputs();
    collect(1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_full_frame_backpressure();
    test_early_last();
    test_overflow();
    test_abort();
    test_clr_in_done();
    test_reset_mid_frame();
    test_back_to_back();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/approx_mul_accumulator.md
# approx_mul_accumulator

Downstream stage of the 8x8 approximate multiplier. Consumes one 16-bit product per accepted beat and accumulates a frame of up to LEN products into an ACC_W-bit sum, for dot-product and FIR-style error studies. Presents the frame result on a valid/ready output port. Applies back-pressure to the multiplier-side producer while a result is waiting.

## Interface
Parameters:
- ACC_W, 24, accumulator and result width; legal range 16..32.
- LEN, 8, products per frame; legal range 1..255.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort of the current frame.
- in_valid  input  1  in_prod is valid this cycle.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  16  product from the multiplier (final_sum), unsigned.
- in_last  input  1  accepted beat closes the frame early.
- out_valid  output  1  frame result is valid.
- out_ready  input  1  consumer takes the result this cycle.
- out_acc  output  ACC_W  accumulated frame sum.
- out_count  output  8  number of products in the frame.
- out_ovf  output  1  the accumulator exceeded 2^ACC_W−1 during the frame.

## Operation
- A beat is accepted when in_valid & in_ready are both high at a rising edge.
- in_prod is zero-extended to ACC_W before addition.
- State machine:
  - IDLE: in_ready=1, acc=0, cnt=0. An accepted beat loads acc=in_prod, cnt=1, then goes to DONE if it is the last beat, otherwise to ACCUM.
  - ACCUM: in_ready=1. An accepted beat adds in_prod into acc and increments cnt. If it is the last beat, go to DONE.
  - DONE: in_ready=0, out_valid=1. On out_ready, go to IDLE and clear acc, cnt and ovf.
- A beat is "last" when in_last=1 or the post-increment cnt equals LEN.
- Overflow: if the carry out of the ACC_W-bit add is 1, ovf is set and stays set until the frame is consumed. Result arithmetic is defined under Configuration.
- clr:
  - Priority: clr beats every other event.
  - Effect: returns the block to IDLE and clears acc, cnt and ovf.
  - in_ready is forced to 0 combinationally while clr=1, so no beat is accepted in that cycle.
  - clr in DONE discards the pending result; out_valid drops on the next cycle.
- Output mapping: out_acc, out_count and out_ovf are driven directly from the registered acc, cnt and ovf. They are meaningful only while out_valid=1 and stay stable until the output handshake completes.

## Timing
- Reset values: out_valid=0, out_acc=0, out_count=0, out_ovf=0, state=IDLE.
- in_ready is combinational from state and clr. While RST_N=0 it reads 1 in IDLE.
- Latency: out_valid rises on the first edge after the accepted last beat, i.e. 1 cycle.
- Throughput:
  - One product per cycle inside a frame.
  - One dead cycle per frame: the DONE cycle in which out_ready=1.
  - No new beat is accepted in DONE; in_ready returns to 1 on the cycle after the output handshake.
- out_valid, once high, is held with constant data until out_ready=1 or clr=1. It never drops on its own.
- LEN=1: every accepted beat goes straight to DONE.
- in_last on the beat that also reaches LEN behaves as a single frame end.
- Reset mid-frame: asynchronous return to the reset values. The partial frame is lost and no result is emitted.

## Configuration
- ACC_SAT_EN defined:
  - On an add carry-out, acc is clamped to all-ones (2^ACC_W−1) and ovf is set.
  - Later adds in the same frame keep acc at all-ones.
- ACC_SAT_EN undefined:
  - acc wraps modulo 2^ACC_W, i.e. it keeps the low ACC_W bits.
  - ovf is still set, and stays set, on the first carry-out.

## Test plan
- Full frame (LEN=4, ACC_W=24): beats 100, 200, 300, 400 on consecutive cycles -> one cycle after the 4th accept, out_valid=1, out_acc=1000, out_count=4, out_ovf=0.
- Back-pressure: as above with out_ready held 0 for 5 cycles -> out_valid, out_acc and out_count stay stable and in_ready=0 throughout. out_ready=1 -> next cycle out_valid=0 and in_ready=1.
- Early last (LEN=8): beats 0xFFFF, then 0x0001 with in_last=1 -> out_acc=0x010000, out_count=2.
- Overflow (ACC_W=16, LEN=2): beats 0xFFFF, 0x0002 -> with ACC_SAT_EN, out_acc=0xFFFF and out_ovf=1; without it, out_acc=0x0001 and out_ovf=1.
- Abort: LEN=4, two beats of 50, then clr=1 with in_valid=1 -> in_ready=0 in the clr cycle. A following frame of four beats of 10 gives out_acc=40, out_count=4.
- Reset mid-frame: RST_N pulsed low after 3 of 4 beats -> all outputs go to 0 immediately and no out_valid follows. The next full frame of 1, 2, 3, 4 gives out_acc=10.
